// File: rtl/rom_arbiter_if.sv
// Bus bundle between the two ROM requesters, the shared ROM and the arbiter.
interface rom_arbiter_if #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32
);
    logic                     req0;
    logic [ADDRESS_WIDTH-1:0] addr0;
    logic                     ack0;
    logic                     rvalid0;
    logic [DATA_WIDTH-1:0]    rdata0;
    logic                     rerr0;
    logic                     req1;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic                     ack1;
    logic                     rvalid1;
    logic [DATA_WIDTH-1:0]    rdata1;
    logic                     rerr1;
    logic [ADDRESS_WIDTH-1:0] rom_a;
    logic [DATA_WIDTH-1:0]    rom_rd;

    modport slave (
        input  req0, addr0, req1, addr1, rom_rd,
        output ack0, rvalid0, rdata0, rerr0,
        output ack1, rvalid1, rdata1, rerr1, rom_a
    );

    modport master (
        output req0, addr0, req1, addr1, rom_rd,
        input  ack0, rvalid0, rdata0, rerr0,
        input  ack1, rvalid1, rdata1, rerr1, rom_a
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of an asynchronous-read ROM.
// Responses arrive one cycle after acceptance; misaligned reads flag rerr.
module rom_arbiter #(
    parameter int ADDRESS_WIDTH = 20,
    parameter int DATA_WIDTH    = 32
) (
    input  logic          clk,
    input  logic          rst,
    rom_arbiter_if.slave  bus
);
    logic                     last_grant_q, last_grant_d;
    logic [ADDRESS_WIDTH-1:0] rom_a_q, rom_a_d;
    logic                     rvalid0_q, rvalid0_d;
    logic                     rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
    logic                     rerr0_q, rerr0_d;
    logic                     rerr1_q, rerr1_d;

    logic                     ack0, ack1, accept, misalign;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    word;

    // last_grant_q names the port that lost nothing last time: the other one wins a tie
    always_comb begin
        ack0     = ~rst & bus.req0 & (~bus.req1 | last_grant_q);
        ack1     = ~rst & bus.req1 & (~bus.req0 | ~last_grant_q);
        accept   = ack0 | ack1;
        sel_addr = ack0 ? bus.addr0 : bus.addr1;
        misalign = |sel_addr[1:0];
        word     = misalign ? '0 : bus.rom_rd;

        last_grant_d = accept ? ack1 : last_grant_q;
        rom_a_d      = accept ? sel_addr : rom_a_q;
        rvalid0_d    = ack0;
        rvalid1_d    = ack1;
        rdata0_d     = ack0 ? word : rdata0_q;
        rerr0_d      = ack0 ? misalign : rerr0_q;
        rdata1_d     = ack1 ? word : rdata1_q;
        rerr1_d      = ack1 ? misalign : rerr1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            rom_a_q      <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rerr0_q      <= 1'b0;
            rerr1_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rom_a_q      <= rom_a_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rerr0_q      <= rerr0_d;
            rerr1_q      <= rerr1_d;
        end
    end

    assign bus.ack0    = ack0;
    assign bus.ack1    = ack1;
    assign bus.rom_a   = rom_a_d;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rerr0   = rerr0_q;
    assign bus.rerr1   = rerr1_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Randomised scoreboard bench for rom_arbiter with a behavioural ROM.
module tb_rom_arbiter;
    localparam int AW = 20;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    rom_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [DW-1:0] rom_word(logic [AW-1:0] a);
        if (a == 20'h00010) return 32'hDEAD_BEEF;
        return {a[11:0], a} ^ 32'h3C5A_96E1;
    endfunction

    assign bus.rom_rd = rom_word(bus.rom_a);

    int n_chk = 0;
    int n_fail = 0;
    resp_t q0[$];
    resp_t q1[$];
    logic [DW-1:0] h0d = '0, h1d = '0;
    logic h0e = 1'b0, h1e = 1'b0;
    logic lg = 1'b1;
    logic [AW-1:0] ra_exp = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic resp_t expect_resp(logic [AW-1:0] a);
        resp_t r;
        r.e = (a[1:0] != 2'b00);
        r.d = r.e ? '0 : rom_word(a);
        return r;
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        h0d = '0;
        h1d = '0;
        h0e = 1'b0;
        h1e = 1'b0;
        lg = 1'b1;
        ra_exp = '0;
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        model_reset();
        #1;
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_rom_a", bus.rom_a, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);
        chk("rst_rvalid", {bus.rvalid0, bus.rvalid1}, 0);
        // requests during reset must never be acked
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        #1;
        chk("rst_ack_req", {bus.ack0, bus.ack1}, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic step(bit r0, logic [AW-1:0] a0, bit r1, logic [AW-1:0] a1);
        int g;
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = r0;
        bus.addr0 = a0;
        bus.req1 = r1;
        bus.addr1 = a1;
        #1;
        g = -1;
        if (r0 && r1) g = lg ? 0 : 1;
        else if (r0) g = 0;
        else if (r1) g = 1;
        chk("ack0", bus.ack0, g == 0);
        chk("ack1", bus.ack1, g == 1);
        if (g == 0) ra_exp = a0;
        if (g == 1) ra_exp = a1;
        chk("rom_a", bus.rom_a, ra_exp);
        @(posedge clk);
        if (g == 0) q0.push_back(expect_resp(a0));
        if (g == 1) q1.push_back(expect_resp(a1));
        if (g >= 0) lg = g[0];
    endtask

    task automatic accept_then_reset(logic [AW-1:0] a0);
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b1;
        bus.addr0 = a0;
        bus.req1 = 1'b0;
        #1;
        chk("ar_ack0", bus.ack0, 1);
        @(posedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        model_reset();
        @(negedge clk);
        chk("ar_rvalid0", bus.rvalid0, 0);
        chk("ar_rdata0", bus.rdata0, 0);
    endtask

    // monitor: one pending response per port must surface on the very next edge
    initial begin
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("rvalid0", bus.rvalid0, q0.size() != 0);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                h0d = e.d;
                h0e = e.e;
            end
            chk("rdata0", bus.rdata0, h0d);
            chk("rerr0", bus.rerr0, h0e);
            chk("rvalid1", bus.rvalid1, q1.size() != 0);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                h1d = e.d;
                h1e = e.e;
            end
            chk("rdata1", bus.rdata1, h1d);
            chk("rerr1", bus.rerr1, h1e);
        end
    end

    initial begin
        logic [AW-1:0] ra, rb;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.addr0 = '0;
        bus.addr1 = '0;
        do_reset(2);

        step(1, 20'h00010, 0, 20'h0);
        step(0, 20'h0, 0, 20'h0);
        chk("deadbeef", bus.rdata0, 32'hDEAD_BEEF);

        do_reset(1);
        repeat (4) step(1, 20'h00000, 1, 20'h00100);
        step(0, 20'h0, 0, 20'h0);

        step(0, 20'h0, 1, 20'h00006);
        step(1, 20'h00020, 1, 20'h00024);
        step(0, 20'h0, 0, 20'h0);

        accept_then_reset(20'h00040);
        step(1, 20'h00044, 1, 20'h00048);
        step(0, 20'h0, 0, 20'h0);

        repeat (3) step(0, 20'h0, 1, 20'h00300);
        repeat (2) step(1, 20'h00400, 1, 20'h00300);

        step(0, 20'h0, 1, 20'h00200);
        repeat (5) step(0, 20'h0, 0, 20'h0);
        chk("hold_rom_a", bus.rom_a, 20'h00200);

        step(1, 20'hFFFFC, 1, 20'hFFFFF);
        step(1, 20'hFFFFC, 1, 20'hFFFFF);
        step(1, 20'hFFFFE, 0, 20'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset($urandom_range(0, 2));
            ra = AW'($urandom);
            rb = AW'($urandom);
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), rb);
        end
        step(0, 20'h0, 0, 20'h0);
        step(0, 20'h0, 0, 20'h0);
        chk("q_drained", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
